// File: rtl/syst_feeder_if.sv
// Handshake bundle between the activation/weight buffers and syst_feeder:
// serial weight stream plus activation vector stream, each with valid/ready.
interface syst_feeder_if #(
    parameter int COL     = 4,
    parameter int X_WIDTH = 8,
    parameter int W_WIDTH = 8
);
    logic [W_WIDTH-1:0]     w_data;
    logic                   w_valid;
    logic                   w_ready;
    logic [COL*X_WIDTH-1:0] vec;
    logic                   vec_valid;
    logic                   vec_last;
    logic                   vec_ready;

    modport master (
        output w_data, w_valid, vec, vec_valid, vec_last,
        input  w_ready, vec_ready
    );

    modport slave (
        input  w_data, w_valid, vec, vec_valid, vec_last,
        output w_ready, vec_ready
    );
endinterface

// File: rtl/syst_feeder.sv
// Weight loader and diagonal activation skewer feeding a weight-stationary systolic array.
// Build option SYST_FEEDER_ZERO_FILL_EN: drive zero data on lanes during bubbles.
module syst_feeder #(
    parameter int COL     = 4,
    parameter int STR     = 4,
    parameter int X_WIDTH = 8,
    parameter int W_WIDTH = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    syst_feeder_if.slave                        bus,
    output logic [COL-1:0][X_WIDTH-1:0]         x_o,
    output logic [COL-1:0]                      valid_o,
    output logic [STR-1:0][COL-1:0][W_WIDTH-1:0] weight_o,
    output logic [STR-1:0][COL-1:0]             valid_w_o,
    output logic                                busy_o,
    output logic                                done_o
);
    localparam int NW = STR * COL;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

    state_t              state_q;
    logic [CW-1:0]       wCnt_q;
    logic [NW*W_WIDTH-1:0] weight_q;
    logic                validW_q;
    logic                done_q;

    logic                wAccept;
    logic                vecAccept;
    logic                lastWeight;
    logic                skewDrained;
    logic [COL-1:0]      laneNextBusy;

    assign bus.w_ready   = (state_q == LOAD_W);
    assign bus.vec_ready = (state_q == STREAM);
    assign wAccept       = bus.w_ready & bus.w_valid;
    assign vecAccept     = bus.vec_ready & bus.vec_valid;
    assign lastWeight    = (wCnt_q == CW'(NW - 1));
    assign skewDrained   = ~|laneNextBusy;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            wCnt_q   <= '0;
            weight_q <= '0;
            validW_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            validW_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= LOAD_W;
                        wCnt_q  <= '0;
                    end
                end
                LOAD_W: begin
                    if (wAccept) begin
                        // Row-major order makes entry k sit at flat offset k*W_WIDTH.
                        for (int k = 0; k < NW; k++) begin
                            if (wCnt_q == CW'(k)) begin
                                weight_q[k*W_WIDTH +: W_WIDTH] <= bus.w_data;
                            end
                        end
                        if (lastWeight) begin
                            wCnt_q   <= '0;
                            validW_q <= 1'b1;
                            state_q  <= STREAM;
                        end else begin
                            wCnt_q <= wCnt_q + CW'(1);
                        end
                    end
                end
                STREAM: begin
                    if (vecAccept && bus.vec_last) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (skewDrained) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar j = 0; j < COL; j++) begin : g_lane
        logic [X_WIDTH-1:0] dat_q [j+1];
        logic [j:0]         vld_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int s = 0; s <= j; s++) begin
                    dat_q[s] <= '0;
                end
                vld_q <= '0;
            end else begin
                vld_q[0] <= vecAccept;
                for (int s = 1; s <= j; s++) begin
                    vld_q[s] <= vld_q[s-1];
                end
`ifdef SYST_FEEDER_ZERO_FILL_EN
                dat_q[0] <= vecAccept ? bus.vec[j*X_WIDTH +: X_WIDTH] : '0;
                for (int s = 1; s <= j; s++) begin
                    dat_q[s] <= vld_q[s-1] ? dat_q[s-1] : '0;
                end
`else
                // Data only moves with a valid token, so bubbles keep the last operand.
                if (vecAccept) begin
                    dat_q[0] <= bus.vec[j*X_WIDTH +: X_WIDTH];
                end
                for (int s = 1; s <= j; s++) begin
                    if (vld_q[s-1]) begin
                        dat_q[s] <= dat_q[s-1];
                    end
                end
`endif
            end
        end

        // Lane stays busy next cycle if anything is about to shift into its stages.
        if (j == 0) begin : g_first
            assign laneNextBusy[j] = vecAccept;
        end else begin : g_rest
            assign laneNextBusy[j] = vecAccept | (|vld_q[j-1:0]);
        end

        assign x_o[j]     = dat_q[j];
        assign valid_o[j] = vld_q[j];
    end

    assign weight_o  = weight_q;
    assign valid_w_o = {NW{validW_q}};
    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;
endmodule

// File: tb/tb_syst_feeder.sv
// Randomized self-checking bench for syst_feeder against a cycle-schedule reference model.
// The model honours SYST_FEEDER_ZERO_FILL_EN for bubble data expectations.
module tb_syst_feeder;
    localparam int COL  = 4;
    localparam int STR  = 4;
    localparam int XW   = 8;
    localparam int WW   = 8;
    localparam int NW   = STR * COL;
    localparam int MAXC = 4096;
    localparam int S_IDLE = 0, S_LOAD = 1, S_STREAM = 2, S_DRAIN = 3;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic start = 1'b0;
    logic [COL-1:0][XW-1:0]          x;
    logic [COL-1:0]                  valid;
    logic [STR-1:0][COL-1:0][WW-1:0] weight;
    logic [STR-1:0][COL-1:0]         validW;
    logic                            busy;
    logic                            done;

    syst_feeder_if #(.COL(COL), .X_WIDTH(XW), .W_WIDTH(WW)) bus ();

    syst_feeder #(.COL(COL), .STR(STR), .X_WIDTH(XW), .W_WIDTH(WW)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .bus       (bus),
        .x_o       (x),
        .valid_o   (valid),
        .weight_o  (weight),
        .valid_w_o (validW),
        .busy_o    (busy),
        .done_o    (done)
    );

    always #5 clk = ~clk;

    int cyc;
    int checkCount;
    int errCount;
    int mState;
    int wCount;
    int doneCycle;
    int vwCycle;
    logic [WW-1:0] mW [NW];
    logic          expV [MAXC][COL];
    logic [XW-1:0] expX [MAXC][COL];
    logic [XW-1:0] lastX [COL];

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic modelReset();
        mState    = S_IDLE;
        wCount    = 0;
        doneCycle = -1;
        vwCycle   = -1;
        for (int k = 0; k < NW; k++) mW[k] = '0;
        for (int c = 0; c < MAXC; c++) begin
            for (int j = 0; j < COL; j++) begin
                expV[c][j] = 1'b0;
                expX[c][j] = '0;
            end
        end
        for (int j = 0; j < COL; j++) lastX[j] = '0;
    endtask

    // One clock cycle: drive inputs, check outputs at negedge, advance the model.
    task automatic applyStimulus(input logic st, input logic wv, input logic [WW-1:0] wd,
                                 input logic vv, input logic [COL*XW-1:0] vec, input logic last);
        logic [COL-1:0][XW-1:0] ex;
        logic [COL-1:0]         ev;
        logic [NW*WW-1:0]       ew;
        int                     nextState;
        start         = st;
        bus.w_valid   = wv;
        bus.w_data    = wd;
        bus.vec_valid = vv;
        bus.vec       = vec;
        bus.vec_last  = last;
        @(negedge clk);
        for (int j = 0; j < COL; j++) begin
            ev[j] = expV[cyc][j];
`ifdef SYST_FEEDER_ZERO_FILL_EN
            ex[j] = ev[j] ? expX[cyc][j] : '0;
`else
            ex[j] = ev[j] ? expX[cyc][j] : lastX[j];
`endif
        end
        for (int k = 0; k < NW; k++) ew[k*WW +: WW] = mW[k];
        checkOutput("busy",      256'(busy),          256'(mState != S_IDLE));
        checkOutput("w_ready",   256'(bus.w_ready),   256'(mState == S_LOAD));
        checkOutput("vec_ready", 256'(bus.vec_ready), 256'(mState == S_STREAM));
        checkOutput("done",      256'(done),          256'(cyc == doneCycle));
        checkOutput("valid_w",   256'(validW),        256'({NW{cyc == vwCycle}}));
        checkOutput("valid",     256'(valid),         256'(ev));
        checkOutput("x",         256'(x),             256'(ex));
        checkOutput("weight",    256'(weight),        256'(ew));
        for (int j = 0; j < COL; j++) if (ev[j]) lastX[j] = ex[j];

        nextState = mState;
        case (mState)
            S_IDLE: if (st) begin
                nextState = S_LOAD;
                wCount    = 0;
            end
            S_LOAD: if (wv) begin
                mW[wCount] = wd;
                wCount++;
                if (wCount == NW) begin
                    vwCycle   = cyc + 1;
                    nextState = S_STREAM;
                end
            end
            S_STREAM: if (vv) begin
                for (int j = 0; j < COL; j++) begin
                    if (cyc + 1 + j < MAXC) begin
                        expV[cyc+1+j][j] = 1'b1;
                        expX[cyc+1+j][j] = vec[j*XW +: XW];
                    end
                end
                if (last) begin
                    doneCycle = cyc + COL + 1;
                    nextState = S_DRAIN;
                end
            end
            S_DRAIN: if (cyc + 1 == doneCycle) nextState = S_IDLE;
            default: nextState = S_IDLE;
        endcase
        mState = nextState;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic loadJob(input int base);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        for (int k = 0; k < NW; k++) applyStimulus(1'b0, 1'b1, WW'(base + k), 1'b0, '0, 1'b0);
    endtask

    // Asserts reset mid-cycle and checks that every output clears without a clock edge.
    task automatic resetDut();
        start         = 1'b0;
        bus.w_valid   = 1'b0;
        bus.w_data    = '0;
        bus.vec_valid = 1'b0;
        bus.vec       = '0;
        bus.vec_last  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_busy",      256'(busy),          256'(0));
        checkOutput("rst_done",      256'(done),          256'(0));
        checkOutput("rst_w_ready",   256'(bus.w_ready),   256'(0));
        checkOutput("rst_vec_ready", 256'(bus.vec_ready), 256'(0));
        checkOutput("rst_x",         256'(x),             256'(0));
        checkOutput("rst_valid",     256'(valid),         256'(0));
        checkOutput("rst_weight",    256'(weight),        256'(0));
        checkOutput("rst_valid_w",   256'(validW),        256'(0));
        @(posedge clk);
        #3;
        rst = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        cyc        = 0;
        checkCount = 0;
        errCount   = 0;
        bus.w_valid   = 1'b0;
        bus.w_data    = '0;
        bus.vec_valid = 1'b0;
        bus.vec       = '0;
        bus.vec_last  = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        resetDut();
        idleCycles(2);

        $display("[TB] weight load 1..16 and single vector");
        loadJob(1);
        for (int r = 0; r < STR; r++) begin
            for (int c = 0; c < COL; c++) begin
                checkOutput("w_matrix", 256'(weight[r][c]), 256'(4 * r + c + 1));
            end
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b1, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b1);
        idleCycles(7);

        $display("[TB] streaming with gap and ignored inputs");
        loadJob(50);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 32'hA4A3A2A1, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 32'hB4B3B2B1, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'hEE, 1'b0, 32'hDEADBEEF, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 32'hC4C3C2C1, 1'b1);
        idleCycles(7);

        $display("[TB] reset during drain");
        loadJob(100);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 32'h11223344, 1'b1);
        idleCycles(1);
        resetDut();
        idleCycles(6);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        idleCycles(2);

        $display("[TB] random traffic");
        for (int n = 0; n < 1500; n++) begin
            logic st, wv, vv, lst;
            logic [WW-1:0]     wd;
            logic [COL*XW-1:0] vec;
            st  = (mState == S_IDLE) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
            wv  = (mState == S_LOAD) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            vv  = (mState == S_STREAM) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
            lst = ($urandom_range(0, 7) == 0);
            wd  = WW'($urandom);
            vec = $urandom;
            applyStimulus(st, wv, wd, vv, vec, lst);
        end
        idleCycles(8);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule
